// File: rtl/bp_pkg.sv
// Shared branch-prediction types: one in-flight prediction record as captured at fetch.
package bp_pkg;

   localparam int BP_IDX_W = 10;

   typedef struct packed {
      logic [BP_IDX_W-1:0] idx;
      logic                pred;
      logic                global_pred;
      logic                local_pred;
      logic [BP_IDX_W-1:0] global_idx;
      logic [BP_IDX_W-1:0] local_idx;
   } bp_entry_t;

endpackage

// File: rtl/bp_update_queue.sv
// In-order queue of prediction metadata from fetch to execute; drives predictor write-back on resolve.
// Latency: resolve -> write 1 cycle; backpressure: full stalls fetch, pushes while full (and not retiring) are dropped.
module bp_update_queue
   import bp_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int IDX_W = BP_IDX_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [IDX_W-1:0]           push_idx,
   input  logic                       push_pred,
   input  logic                       push_global_pred,
   input  logic                       push_local_pred,
   input  logic [IDX_W-1:0]           push_global_idx,
   input  logic [IDX_W-1:0]           push_local_idx,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count,
   input  logic                       resolve,
   input  logic                       resolve_taken,
   input  logic                       flush,
   output logic                       mispredict,
   output logic                       write,
   output logic                       actual_outcome,
   output logic [IDX_W-1:0]           actual_outcome_idx,
   output logic                       global_predicted_outcome_in,
   output logic                       local_predicted_outcome_in,
   output logic [IDX_W-1:0]           global_actual_idx_in,
   output logic [IDX_W-1:0]           local_actual_idx_in
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   bp_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] head, tail, head_inc;
   bp_entry_t        head_e, push_e;
   logic             do_resolve, do_mis, do_push;

   assign full   = (count == CNT_W'(DEPTH));
   assign empty  = (count == '0);
   assign head_e = mem[head];
   assign head_inc = head + PTR_W'(1);

   assign push_e = '{idx:         push_idx,
                     pred:        push_pred,
                     global_pred: push_global_pred,
                     local_pred:  push_local_pred,
                     global_idx:  push_global_idx,
                     local_idx:   push_local_idx};

   assign do_resolve = resolve && !empty;
   assign do_mis     = do_resolve && (resolve_taken != head_e.pred);
   // A correct retirement frees the head slot, so a push is accepted even when full.
   assign do_push    = push && !flush && !do_mis && (!full || do_resolve);

   always_ff @(posedge clk) begin
      if (do_push) mem[tail] <= push_e;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head                        <= '0;
         tail                        <= '0;
         count                       <= '0;
         write                       <= 1'b0;
         mispredict                  <= 1'b0;
         actual_outcome              <= 1'b0;
         actual_outcome_idx          <= '0;
         global_predicted_outcome_in <= 1'b0;
         local_predicted_outcome_in  <= 1'b0;
         global_actual_idx_in        <= '0;
         local_actual_idx_in         <= '0;
      end else begin
         write      <= do_resolve;
         mispredict <= do_mis;
         if (do_resolve) begin
            actual_outcome              <= resolve_taken;
            actual_outcome_idx          <= head_e.idx;
            global_predicted_outcome_in <= head_e.global_pred;
            local_predicted_outcome_in  <= head_e.local_pred;
            global_actual_idx_in        <= head_e.global_idx;
            local_actual_idx_in         <= head_e.local_idx;
         end
         if (flush || do_mis) begin
            // Resolving entry retires first, then everything younger is dropped.
            head  <= do_resolve ? head_inc : head;
            tail  <= do_resolve ? head_inc : head;
            count <= '0;
         end else begin
            if (do_resolve) head <= head_inc;
            if (do_push)    tail <= tail + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_resolve);
         end
      end
   end

endmodule

// File: tb/tb_bp_update_queue.sv
// Directed and model-checked bench for bp_update_queue (DEPTH=4, IDX_W=10).
module tb_bp_update_queue;

   logic       clk = 1'b0;
   logic       rst;
   logic       push;
   logic [9:0] push_idx;
   logic       push_pred, push_global_pred, push_local_pred;
   logic [9:0] push_global_idx, push_local_idx;
   logic       full, empty;
   logic [2:0] count;
   logic       resolve, resolve_taken, flush;
   logic       mispredict, write, actual_outcome;
   logic [9:0] actual_outcome_idx;
   logic       global_predicted_outcome_in, local_predicted_outcome_in;
   logic [9:0] global_actual_idx_in, local_actual_idx_in;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   bp_update_queue #(.DEPTH(4), .IDX_W(10)) dut (
      .clk(clk), .rst(rst), .push(push), .push_idx(push_idx), .push_pred(push_pred),
      .push_global_pred(push_global_pred), .push_local_pred(push_local_pred),
      .push_global_idx(push_global_idx), .push_local_idx(push_local_idx),
      .full(full), .empty(empty), .count(count), .resolve(resolve),
      .resolve_taken(resolve_taken), .flush(flush), .mispredict(mispredict), .write(write),
      .actual_outcome(actual_outcome), .actual_outcome_idx(actual_outcome_idx),
      .global_predicted_outcome_in(global_predicted_outcome_in),
      .local_predicted_outcome_in(local_predicted_outcome_in),
      .global_actual_idx_in(global_actual_idx_in), .local_actual_idx_in(local_actual_idx_in));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      push = 0; resolve = 0; resolve_taken = 0; flush = 0;
   endtask

   task automatic set_push(input logic [9:0] idx, input logic pred, input logic g, input logic l,
                           input logic [9:0] gidx, input logic [9:0] lidx);
      push = 1; push_idx = idx; push_pred = pred; push_global_pred = g;
      push_local_pred = l; push_global_idx = gidx; push_local_idx = lidx;
   endtask

   task automatic do_reset();
      idle(); rst = 1;
      step(); step();
      rst = 0;
   endtask

   task automatic test_reset();
      push_idx = 0; push_pred = 0; push_global_pred = 0; push_local_pred = 0;
      push_global_idx = 0; push_local_idx = 0;
      do_reset();
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
      checks++; if (write !== 1'b0 || mispredict !== 1'b0)
         begin errors++; $display("FAIL reset_pulses write=%b mis=%b exp=0,0", write, mispredict); end
      checks++; if ({actual_outcome, actual_outcome_idx, global_predicted_outcome_in, local_predicted_outcome_in,
                     global_actual_idx_in, local_actual_idx_in} !== 33'd0)
         begin errors++; $display("FAIL reset_data idx=%h gidx=%h lidx=%h exp=0", actual_outcome_idx,
                                  global_actual_idx_in, local_actual_idx_in); end
   endtask

   task automatic test_single();
      set_push(10'h005, 1, 1, 0, 10'h03A, 10'h005);
      step();
      idle();
      checks++; if (count !== 3'd1 || empty !== 1'b0)
         begin errors++; $display("FAIL single_push count=%0d empty=%b exp=1,0", count, empty); end
      resolve = 1; resolve_taken = 1;
      step();
      idle();
      checks++; if (write !== 1'b1 || mispredict !== 1'b0)
         begin errors++; $display("FAIL single_write write=%b mis=%b exp=1,0", write, mispredict); end
      checks++; if (actual_outcome !== 1'b1 || actual_outcome_idx !== 10'h005 || global_predicted_outcome_in !== 1'b1 ||
                    local_predicted_outcome_in !== 1'b0 || global_actual_idx_in !== 10'h03A || local_actual_idx_in !== 10'h005)
         begin errors++; $display("FAIL single_data out=%b idx=%h g=%b l=%b gidx=%h lidx=%h exp=1,005,1,0,03a,005",
                                  actual_outcome, actual_outcome_idx, global_predicted_outcome_in,
                                  local_predicted_outcome_in, global_actual_idx_in, local_actual_idx_in); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty got=%b exp=1", empty); end
      step();
      checks++; if (write !== 1'b0 || actual_outcome_idx !== 10'h005)
         begin errors++; $display("FAIL single_hold write=%b idx=%h exp=0,005", write, actual_outcome_idx); end
   endtask

   task automatic test_full();
      logic [9:0] exp_idx [4];
      logic       exp_pred [4];
      exp_idx = '{10'h011, 10'h012, 10'h013, 10'h015};
      exp_pred = '{1'b1, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
         set_push(10'h010 + 10'(i), 1, 0, 1, 10'h100 + 10'(i), 10'h200 + 10'(i));
         step();
      end
      idle();
      checks++; if (full !== 1'b1 || count !== 3'd4)
         begin errors++; $display("FAIL full_flag full=%b count=%0d exp=1,4", full, count); end
      set_push(10'h014, 0, 0, 0, 10'h0, 10'h0);
      step();
      idle();
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_drop count=%0d exp=4", count); end
      set_push(10'h015, 0, 1, 1, 10'h155, 10'h0AA);
      resolve = 1; resolve_taken = 1;
      step();
      idle();
      checks++; if (write !== 1'b1 || actual_outcome_idx !== 10'h010 || count !== 3'd4 || mispredict !== 1'b0)
         begin errors++; $display("FAIL full_swap write=%b idx=%h count=%0d mis=%b exp=1,010,4,0",
                                  write, actual_outcome_idx, count, mispredict); end
      for (int i = 0; i < 4; i++) begin
         resolve = 1; resolve_taken = exp_pred[i];
         step();
         idle();
         checks++; if (write !== 1'b1 || mispredict !== 1'b0 || actual_outcome_idx !== exp_idx[i])
            begin errors++; $display("FAIL full_drain%0d write=%b mis=%b idx=%h exp=1,0,%h",
                                     i, write, mispredict, actual_outcome_idx, exp_idx[i]); end
      end
      checks++; if (global_actual_idx_in !== 10'h155 || local_actual_idx_in !== 10'h0AA || empty !== 1'b1)
         begin errors++; $display("FAIL full_last gidx=%h lidx=%h empty=%b exp=155,0aa,1",
                                  global_actual_idx_in, local_actual_idx_in, empty); end
   endtask

   task automatic test_mispredict();
      set_push(10'h020, 0, 0, 0, 10'h0, 10'h0); step();
      set_push(10'h021, 1, 0, 0, 10'h0, 10'h0); step();
      set_push(10'h022, 1, 0, 0, 10'h0, 10'h0); step();
      idle();
      resolve = 1; resolve_taken = 1;
      set_push(10'h023, 1, 0, 0, 10'h0, 10'h0);
      step();
      idle();
      checks++; if (write !== 1'b1 || mispredict !== 1'b1 || actual_outcome_idx !== 10'h020)
         begin errors++; $display("FAIL mis_write write=%b mis=%b idx=%h exp=1,1,020", write, mispredict, actual_outcome_idx); end
      checks++; if (count !== 3'd0 || empty !== 1'b1)
         begin errors++; $display("FAIL mis_squash count=%0d empty=%b exp=0,1", count, empty); end
      resolve = 1; resolve_taken = 0;
      step();
      idle();
      checks++; if (write !== 1'b0 || mispredict !== 1'b0 || actual_outcome_idx !== 10'h020)
         begin errors++; $display("FAIL mis_empty_res write=%b mis=%b idx=%h exp=0,0,020", write, mispredict, actual_outcome_idx); end
   endtask

   task automatic test_resolve_empty();
      resolve = 1; resolve_taken = 1;
      step();
      idle();
      checks++; if (write !== 1'b0 || mispredict !== 1'b0 || count !== 3'd0)
         begin errors++; $display("FAIL empty_res write=%b mis=%b count=%0d exp=0,0,0", write, mispredict, count); end
      set_push(10'h0C3, 0, 1, 0, 10'h011, 10'h022); step();
      idle();
      resolve = 1; resolve_taken = 0;
      step();
      idle();
      checks++; if (write !== 1'b1 || mispredict !== 1'b0 || actual_outcome_idx !== 10'h0C3 || global_actual_idx_in !== 10'h011)
         begin errors++; $display("FAIL empty_after write=%b mis=%b idx=%h gidx=%h exp=1,0,0c3,011",
                                  write, mispredict, actual_outcome_idx, global_actual_idx_in); end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) begin
         set_push(10'h030 + 10'(i), 1, 1, 1, 10'h0, 10'h0);
         step();
      end
      idle();
      flush = 1; resolve = 1; resolve_taken = 1;
      set_push(10'h039, 1, 0, 0, 10'h0, 10'h0);
      step();
      idle();
      checks++; if (write !== 1'b1 || actual_outcome_idx !== 10'h030 || mispredict !== 1'b0)
         begin errors++; $display("FAIL flush_res write=%b idx=%h mis=%b exp=1,030,0", write, actual_outcome_idx, mispredict); end
      checks++; if (count !== 3'd0 || empty !== 1'b1)
         begin errors++; $display("FAIL flush_clear count=%0d empty=%b exp=0,1", count, empty); end
      set_push(10'h03F, 0, 0, 1, 10'h2AA, 10'h155); step();
      idle();
      resolve = 1; resolve_taken = 0;
      step();
      idle();
      checks++; if (write !== 1'b1 || mispredict !== 1'b0 || actual_outcome_idx !== 10'h03F || actual_outcome !== 1'b0 ||
                    global_predicted_outcome_in !== 1'b0 || local_predicted_outcome_in !== 1'b1 ||
                    global_actual_idx_in !== 10'h2AA || local_actual_idx_in !== 10'h155)
         begin errors++; $display("FAIL flush_next write=%b mis=%b idx=%h g=%b l=%b gidx=%h lidx=%h exp=1,0,03f,0,1,2aa,155",
                                  write, mispredict, actual_outcome_idx, global_predicted_outcome_in,
                                  local_predicted_outcome_in, global_actual_idx_in, local_actual_idx_in); end
   endtask

   task automatic test_reset_mid();
      set_push(10'h050, 1, 0, 0, 10'h0, 10'h0); step();
      set_push(10'h051, 1, 0, 0, 10'h0, 10'h0); step();
      idle();
      resolve = 1; resolve_taken = 0; rst = 1;
      step();
      idle(); rst = 0;
      checks++; if (write !== 1'b0 || mispredict !== 1'b0 || count !== 3'd0 || actual_outcome_idx !== 10'h0)
         begin errors++; $display("FAIL rst_mid write=%b mis=%b count=%0d idx=%h exp=0,0,0,000",
                                  write, mispredict, count, actual_outcome_idx); end
   endtask

   task automatic test_random();
      logic [9:0] mq_idx[$];
      logic       mq_pred[$];
      logic [9:0] next_idx;
      logic       p, r, t, pr, dres, mis, acc, exp_w, exp_m, exp_o;
      logic [9:0] exp_i;
      next_idx = 10'h100;
      exp_i = actual_outcome_idx;
      for (int cyc = 0; cyc < 20; cyc++) begin
         p  = 1'($urandom_range(0, 3) != 0);
         r  = 1'($urandom_range(0, 1));
         t  = 1'($urandom_range(0, 3) != 0);
         pr = 1'($urandom_range(0, 3) != 0);
         dres = r && (mq_idx.size() > 0);
         mis  = dres && (t != mq_pred[0]);
         acc  = p && !mis && ((mq_idx.size() < 4) || dres);
         exp_w = dres; exp_m = mis; exp_o = t;
         if (dres) begin
            exp_i = mq_idx.pop_front();
            void'(mq_pred.pop_front());
         end
         if (mis) begin mq_idx.delete(); mq_pred.delete(); end
         if (acc) begin mq_idx.push_back(next_idx); mq_pred.push_back(pr); end
         if (p) set_push(next_idx, pr, ~pr, pr, ~next_idx, next_idx ^ 10'h3FF); else push = 0;
         resolve = r; resolve_taken = t;
         if (p) next_idx = next_idx + 10'd1;
         step();
         idle();
         checks++; if (write !== exp_w || mispredict !== exp_m || count !== 3'(mq_idx.size()) ||
                       (exp_w && (actual_outcome_idx !== exp_i || actual_outcome !== exp_o)))
            begin errors++; $display("FAIL rand%0d write=%b mis=%b count=%0d idx=%h out=%b exp=%b,%b,%0d,%h,%b",
                                     cyc, write, mispredict, count, actual_outcome_idx, actual_outcome,
                                     exp_w, exp_m, mq_idx.size(), exp_i, exp_o); end
      end
   endtask

   initial begin
      rst = 1;
      idle();
      test_reset();
      test_single();
      test_full();
      test_mispredict();
      test_resolve_empty();
      test_flush();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
